fdiv_ctrl: RTL and testbench
============================

FDIV_CTRL -- requirements
Module: fdiv_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4: cycles operands are held stable before the quotient is captured (multicycle path), legal range 1..15.
REQ-002 SHALL have parameter TAG_W, default 6: width of the destination-register tag carried with each operation.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port flush, input, 1: aborts any in-flight or pending operation.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both high at a rising edge.
REQ-008 SHALL have port req_x1, input, 32: IEEE-754 single-precision dividend.
REQ-009 SHALL have port req_x2, input, 32: IEEE-754 single-precision divisor.
REQ-010 SHALL have port req_tag, input, TAG_W: destination tag.
REQ-011 SHALL have port res_valid, output, 1: result present.
REQ-012 SHALL have port res_ready, input, 1: result consumed when res_valid and res_ready are both high at a rising edge.
REQ-013 SHALL have port res_y, output, 32: quotient x1/x2.
REQ-014 SHALL have port res_tag, output, TAG_W: tag of the accepted request.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-017 SHALL drive req_ready = 1 in IDLE, 0 in WAIT, and res_ready in DONE; req_ready SHALL be 0 whenever flush = 1.
REQ-018 SHALL, on acceptance, latch req_x1, req_x2 and req_tag into operand registers, load the counter with WAIT_CYCLES-1, and enter WAIT.
REQ-019 SHALL, in WAIT, decrement the counter each cycle while it is nonzero.
REQ-020 SHALL, in WAIT with counter = 0, capture the divider output into res_y at the next edge, set res_valid, and enter DONE.
REQ-021 SHALL assert res_valid exactly WAIT_CYCLES rising edges after the accepting edge.
REQ-022 SHALL keep res_y, res_tag and res_valid stable in DONE until the result handshake completes.
REQ-023 SHALL, on result handshake with no simultaneous accept, clear res_valid and enter IDLE.
REQ-024 SHALL, on result handshake coinciding with req_valid, accept the new request in the same edge and enter WAIT; this gives back-to-back issue without a bubble.
REQ-025 SHALL keep the operand registers unchanged from acceptance until capture; the divider inputs SHALL be driven only from these registers.
REQ-026 SHALL, on flush = 1 at an edge, enter IDLE and clear res_valid; flush SHALL take priority over acceptance, capture and the result handshake.
REQ-027 SHALL pass the divider result bit-exact: no extra rounding, and no special-case handling of NaN, infinity, zero or denormal.

Reset
REQ-028 SHALL, when rstn = 0 at a rising edge, set: state IDLE, counter 0, res_valid 0, res_y 0, res_tag 0, operand registers 0.
REQ-029 SHALL give reset priority over flush and over all handshakes, including reset asserted mid-WAIT or mid-DONE.

Structure
REQ-030 SHALL place the FSM state enum and the default WAIT_CYCLES constant in a shared package, fpu_pkg.
REQ-031 SHALL instantiate exactly one sub-module, the combinational divider fdiv (x1, x2 -> y).
REQ-032 SHALL declare the path from the operand registers through fdiv to res_y as a WAIT_CYCLES multicycle path in the timing constraints.

Verification
REQ-033 SHALL cover this case: accept 0x3F800000 / 0x40000000 with tag 5 and res_ready = 1 -> res_valid rises 4 edges after acceptance, res_y = 0x3F000000, res_tag = 5.
REQ-034 SHALL cover this case: hold res_ready = 0 for 10 cycles after 0x40C00000 / 0x40400000 -> res_y = 0x40000000 held stable, req_ready = 0 throughout, busy = 1.
REQ-035 SHALL cover this case: result handshake with req_valid high, second op 0x41200000 / 0x40000000 -> no bubble, second res_y = 0x40A00000 exactly 4 edges later.
REQ-036 SHALL cover this case: flush asserted two cycles into WAIT -> IDLE next edge, res_valid never rises, the next request completes normally.
REQ-037 SHALL cover this case: rstn = 0 during DONE -> all outputs at reset values after the edge, req_ready = 1.
REQ-038 SHALL cover this case: with WAIT_CYCLES = 1, 0x3F800000 / 0x3F800000 -> res_valid 1 edge after acceptance, res_y = 0x3F800000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU divide controller: FSM state encoding and default timing.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } fdiv_state_t;

    localparam int unsigned FDIV_WAIT_CYCLES_DEF = 4;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fdiv.sv
// Combinational IEEE-754 single-precision divider, round-to-nearest-even.
// Denormal operands and underflowing results are flushed to signed zero.
module fdiv
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);

    logic               sign_s;
    logic [7:0]         e1_s, e2_s;
    logic               nan1_s, nan2_s, inf1_s, inf2_s, zero1_s, zero2_s;
    logic [49:0]        num_s, den_s;
    logic [26:0]        q_s;
    logic [23:0]        rem_s, mant_s;
    logic               grd_s, stk_s, rnd_s;
    logic [24:0]        mant_rnd_s;
    logic [22:0]        frac_s;
    logic signed [9:0]  exp_s;

    // Quotient mantissa, normalisation, rounding and special-value selection
    always_comb begin
        sign_s  = x1[31] ^ x2[31];
        e1_s    = x1[30:23];
        e2_s    = x2[30:23];
        nan1_s  = (e1_s == 8'hFF) && (x1[22:0] != 23'd0);
        nan2_s  = (e2_s == 8'hFF) && (x2[22:0] != 23'd0);
        inf1_s  = (e1_s == 8'hFF) && (x1[22:0] == 23'd0);
        inf2_s  = (e2_s == 8'hFF) && (x2[22:0] == 23'd0);
        zero1_s = (e1_s == 8'h00);
        zero2_s = (e2_s == 8'h00);

        num_s = {1'b1, x1[22:0], 26'd0};
        den_s = {26'd0, 1'b1, x2[22:0]};
        q_s   = 27'(num_s / den_s);
        rem_s = 24'(num_s % den_s);

        // q lies in [2^25, 2^27): the top bit tells whether m1 >= m2
        if (q_s[26]) begin
            mant_s = q_s[26:3];
            grd_s  = q_s[2];
            stk_s  = (|q_s[1:0]) | (|rem_s);
            exp_s  = $signed({2'b00, e1_s}) - $signed({2'b00, e2_s}) + 10'sd127;
        end else begin
            mant_s = q_s[25:2];
            grd_s  = q_s[1];
            stk_s  = q_s[0] | (|rem_s);
            exp_s  = $signed({2'b00, e1_s}) - $signed({2'b00, e2_s}) + 10'sd126;
        end

        rnd_s      = grd_s & (stk_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {24'd0, rnd_s};
        if (mant_rnd_s[24]) begin
            frac_s = mant_rnd_s[23:1];
            exp_s  = exp_s + 10'sd1;
        end else begin
            frac_s = mant_rnd_s[22:0];
        end

        if (nan1_s || nan2_s || (zero1_s && zero2_s) || (inf1_s && inf2_s)) begin
            y = FP_QNAN;
        end else if (inf1_s || zero2_s) begin
            y = {sign_s, 8'hFF, 23'd0};
        end else if (zero1_s || inf2_s) begin
            y = {sign_s, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            y = {sign_s, 8'hFF, 23'd0};
        end else if (exp_s <= 10'sd0) begin
            y = {sign_s, 31'd0};
        end else begin
            y = {sign_s, exp_s[7:0], frac_s};
        end
    end

endmodule

// File: rtl/fdiv_ctrl.sv
// Multicycle divide controller: holds operands for WAIT_CYCLES around a combinational
// fdiv, whose operand-register-to-res_y path is constrained as a WAIT_CYCLES multicycle path.
module fdiv_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = FDIV_WAIT_CYCLES_DEF,
    parameter int unsigned TAG_W       = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_y,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    fdiv_state_t      state_r;
    logic [3:0]       cnt_r;
    logic [31:0]      op_x1_r, op_x2_r, res_y_r, div_y_s;
    logic [TAG_W-1:0] op_tag_r, res_tag_r;
    logic             res_valid_r, req_ready_s;

    fdiv u_fdiv (
        .x1 (op_x1_r),
        .x2 (op_x2_r),
        .y  (div_y_s)
    );

    // Request-side readiness; DONE can accept only as the result drains
    always_comb begin
        req_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: req_ready_s = 1'b1;
            ST_WAIT: req_ready_s = 1'b0;
            ST_DONE: req_ready_s = res_ready;
            default: req_ready_s = 1'b0;
        endcase
        if (flush) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = req_ready_s;
        end
    end

    // Controller FSM with operand and result registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            op_x1_r     <= 32'd0;
            op_x2_r     <= 32'd0;
            op_tag_r    <= {TAG_W{1'b0}};
            res_y_r     <= 32'd0;
            res_tag_r   <= {TAG_W{1'b0}};
            res_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_x1_r  <= req_x1;
                        op_x2_r  <= req_x2;
                        op_tag_r <= req_tag;
                        cnt_r    <= CNT_LOAD;
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        res_y_r     <= div_y_s;
                        res_tag_r   <= op_tag_r;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        if (req_valid) begin
                            op_x1_r  <= req_x1;
                            op_x2_r  <= req_x2;
                            op_tag_r <= req_tag;
                            cnt_r    <= CNT_LOAD;
                            state_r  <= ST_WAIT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign res_valid = res_valid_r;
    assign res_y     = res_y_r;
    assign res_tag   = res_tag_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: latency, back-pressure, back-to-back issue, flush, reset
// and a WAIT_CYCLES=1 instance.
module tb_fdiv_ctrl;

    logic        clk = 1'b0;
    logic        rstn, flush, req_valid, req_valid_w1, res_ready;
    logic [31:0] req_x1, req_x2;
    logic [5:0]  req_tag;
    logic        req_ready, res_valid, busy;
    logic [31:0] res_y;
    logic [5:0]  res_tag;
    logic        req_ready_w1, res_valid_w1, busy_w1;
    logic [31:0] res_y_w1;
    logic [5:0]  res_tag_w1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fdiv_ctrl #(.WAIT_CYCLES(4), .TAG_W(6)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_tag(res_tag), .busy(busy)
    );

    fdiv_ctrl #(.WAIT_CYCLES(1), .TAG_W(6)) dut_w1 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid_w1), .req_ready(req_ready_w1),
        .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
        .res_valid(res_valid_w1), .res_ready(res_ready),
        .res_y(res_y_w1), .res_tag(res_tag_w1), .busy(busy_w1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_valid_w1 = 1'b0;
        res_ready = 1'b0; req_x1 = 32'd0; req_x2 = 32'd0; req_tag = 6'd0;
        step(); step();
        check("rst_res_valid", res_valid, 32'd0);
        check("rst_res_y", res_y, 32'd0);
        check("rst_res_tag", res_tag, 32'd0);
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_w1_valid", res_valid_w1, 32'd0);
        rstn = 1'b1;

        // 1.0 / 2.0, tag 5, consumer always ready
        req_valid = 1'b1; req_x1 = 32'h3F80_0000; req_x2 = 32'h4000_0000;
        req_tag = 6'd5; res_ready = 1'b1;
        step();
        check("t1_busy", busy, 32'd1);
        check("t1_req_ready_wait", req_ready, 32'd0);
        req_valid = 1'b0; req_x1 = 32'hDEAD_BEEF; req_x2 = 32'h1234_5678; req_tag = 6'd63;
        for (int i = 1; i < 4; i++) begin
            step();
            check("t1_valid_early", res_valid, 32'd0);
        end
        step();
        check("t1_valid", res_valid, 32'd1);
        check("t1_y", res_y, 32'h3F00_0000);
        check("t1_tag", res_tag, 32'd5);
        check("t1_req_ready_done", req_ready, 32'd1);
        step();
        check("t1_drain_valid", res_valid, 32'd0);
        check("t1_drain_busy", busy, 32'd0);

        // 6.0 / 3.0 with the consumer stalled; new operands presented during the wait
        req_valid = 1'b1; req_x1 = 32'h40C0_0000; req_x2 = 32'h4040_0000;
        req_tag = 6'd9; res_ready = 1'b0;
        step();
        req_x1 = 32'h4120_0000; req_x2 = 32'h3F80_0000; req_tag = 6'd1;
        for (int i = 1; i < 4; i++) step();
        step();
        check("t2_valid", res_valid, 32'd1);
        check("t2_y", res_y, 32'h4000_0000);
        check("t2_tag", res_tag, 32'd9);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_hold_valid", res_valid, 32'd1);
            check("t2_hold_y", res_y, 32'h4000_0000);
            check("t2_hold_tag", res_tag, 32'd9);
            check("t2_hold_req_ready", req_ready, 32'd0);
            check("t2_hold_busy", busy, 32'd1);
        end

        // Drain plus immediate issue of 10.0 / 2.0
        res_ready = 1'b1; req_valid = 1'b1; req_x1 = 32'h4120_0000; req_x2 = 32'h4000_0000;
        req_tag = 6'd12;
        step();
        check("t3_valid_cleared", res_valid, 32'd0);
        check("t3_busy", busy, 32'd1);
        req_valid = 1'b0; res_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            check("t3_valid_early", res_valid, 32'd0);
        end
        step();
        check("t3_valid", res_valid, 32'd1);
        check("t3_y", res_y, 32'h40A0_0000);
        check("t3_tag", res_tag, 32'd12);

        // Reset while a result is waiting in DONE
        step();
        check("t5_pre_valid", res_valid, 32'd1);
        rstn = 1'b0;
        step();
        check("t5_valid", res_valid, 32'd0);
        check("t5_y", res_y, 32'd0);
        check("t5_tag", res_tag, 32'd0);
        check("t5_req_ready", req_ready, 32'd1);
        check("t5_busy", busy, 32'd0);
        rstn = 1'b1;

        // Flush two cycles into WAIT, then a normal request
        req_valid = 1'b1; req_x1 = 32'h3F80_0000; req_x2 = 32'h4000_0000;
        req_tag = 6'd3; res_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step(); step();
        flush = 1'b1;
        step();
        check("t4_busy", busy, 32'd0);
        check("t4_valid", res_valid, 32'd0);
        check("t4_req_ready_flush", req_ready, 32'd0);
        flush = 1'b0;
        #1;
        check("t4_req_ready", req_ready, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t4_no_valid", res_valid, 32'd0);
        end
        req_valid = 1'b1; req_x1 = 32'h40C0_0000; req_x2 = 32'h4040_0000; req_tag = 6'd7;
        step();
        req_valid = 1'b0;
        for (int i = 1; i < 4; i++) step();
        step();
        check("t4_next_valid", res_valid, 32'd1);
        check("t4_next_y", res_y, 32'h4000_0000);
        check("t4_next_tag", res_tag, 32'd7);

        // WAIT_CYCLES = 1 instance: 1.0 / 1.0
        req_valid_w1 = 1'b1; req_x1 = 32'h3F80_0000; req_x2 = 32'h3F80_0000; req_tag = 6'd2;
        step();
        req_valid_w1 = 1'b0;
        check("t6_valid_early", res_valid_w1, 32'd0);
        step();
        check("t6_valid", res_valid_w1, 32'd1);
        check("t6_y", res_y_w1, 32'h3F80_0000);
        check("t6_tag", res_tag_w1, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
